// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and helpers for the
// read-domain FIFO packer.
package fifo_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic {FILL, DRAIN} rdpk_state_t;

  // Low cnt lanes set; lanes at or above pack stay clear.
  function automatic logic [63:0] keep_mask(
    input int cnt,
    input int pack
  );
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < cnt && i < pack) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if: packed-word valid/ready stream
// leaving the read-domain packer.
interface fifo_rd_packer_if #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int PACK       = 4
);

  logic                       m_valid;
  logic                       m_ready;
  logic [DATA_WIDTH*PACK-1:0] m_data;
  logic [PACK-1:0]            m_keep;

  modport master (
    output m_valid,
    output m_data,
    output m_keep,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_keep,
    output m_ready
  );

endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains the async FIFO read port and
// packs PACK entries per word onto a valid/ready stream.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int PACK       = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  fifo_rempty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_read_enable,
  input  logic                  flush,
  fifo_rd_packer_if.master      m,
  output logic [CNT_W-1:0]      word_count
);

  import fifo_pkg::*;

  localparam int CW = $clog2(PACK + 1);
  localparam int LI = $clog2(PACK);

  localparam logic [CW:0]   PACK_S = (CW+1)'(PACK);
  localparam logic [CW-1:0] FULL_C = CW'(PACK);
  localparam logic [CW-1:0] LAST_C = CW'(PACK - 1);

  rdpk_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic r_pend;
  logic r_flush_req;
  logic r_valid;
  logic [PACK-1:0][DATA_WIDTH-1:0] r_asm;
  logic [PACK-1:0][DATA_WIDTH-1:0] r_data;
  logic [PACK-1:0] r_keep;
  logic [CNT_W-1:0] r_wcnt;

  logic [PACK-1:0][DATA_WIDTH-1:0] w_word;
  logic [PACK-1:0] w_keep;
  logic [CW:0] w_sum;
  logic [LI-1:0] w_lane;
  logic w_free;
  logic w_rd;
  logic w_done;
  logic w_full;
  logic w_idle;
  logic w_emit;
  logic w_drain_end;
  logic w_load;

  assign w_free = !r_valid || m.m_ready;
  assign w_sum  = {1'b0, r_cnt} + {{CW{1'b0}}, r_pend};
  assign w_lane = r_cnt[LI-1:0];

  // A read may be issued one word ahead when the
  // landing byte completes a word into a free slot.
  assign w_rd = rrst_n
             && (r_state == FILL)
             && !fifo_rempty
             && !r_flush_req
             && (w_sum < PACK_S
                 || (w_sum == PACK_S
                     && r_pend && w_free));

  assign w_done = r_pend && (r_cnt == LAST_C)
               && w_free;
  assign w_full = !r_pend && (r_cnt == FULL_C)
               && w_free;
  assign w_idle = (r_state == DRAIN) && !r_pend;
  assign w_emit = w_idle && (r_cnt != '0) && w_free;
  assign w_drain_end = w_idle
                    && ((r_cnt == '0) || w_free);
  assign w_load = w_done || w_full || w_emit;

  // Next output word: assembly plus landing byte,
  // lanes beyond the fill level forced to zero.
  always_comb begin
    w_keep = PACK'(keep_mask(
      w_done ? PACK : int'(r_cnt), PACK));
    w_word = r_asm;
    if (w_done) w_word[PACK-1] = fifo_rdata;
    for (int i = 0; i < PACK; i++) begin
      if (!w_keep[i]) w_word[i] = '0;
    end
  end

  // Flush control: latch request, drain, return.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state     <= FILL;
      r_flush_req <= 1'b0;
    end else begin
      unique case (r_state)
        FILL: begin
          if (flush) r_flush_req <= 1'b1;
          if (r_flush_req) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_drain_end) begin
            r_flush_req <= 1'b0;
            r_state     <= FILL;
          end
        end
      endcase
    end
  end

  // Landing, lane assembly and output slot.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_pend  <= 1'b0;
      r_cnt   <= '0;
      r_asm   <= '0;
      r_data  <= '0;
      r_keep  <= '0;
      r_valid <= 1'b0;
      r_wcnt  <= '0;
    end else begin
      r_pend <= w_rd;
      if (r_pend && !w_done) begin
        r_asm[w_lane] <= fifo_rdata;
      end
      if (w_load) begin
        r_cnt <= '0;
      end else if (r_pend) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_load) begin
        r_data  <= w_word;
        r_keep  <= w_keep;
        r_valid <= 1'b1;
      end else if (m.m_ready) begin
        r_valid <= 1'b0;
      end
      if (r_valid && m.m_ready) begin
        r_wcnt <= r_wcnt + CNT_W'(1);
      end
    end
  end

  assign fifo_read_enable = w_rd;
  assign m.m_valid        = r_valid;
  assign m.m_data         = r_data;
  assign m.m_keep         = r_keep;
  assign word_count       = r_wcnt;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed and random checks of the
// packer against a byte-grouping reference model.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PK = 4;
  localparam int CW = 16;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic          fifo_rempty = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_read_enable;
  logic          flush = 1'b0;
  logic [CW-1:0] word_count;

  fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK(PK)) mif ();

  fifo_rd_packer #(
    .DATA_WIDTH(DW),
    .PACK(PK),
    .CNT_W(CW)
  ) dut (
    .rclk             (rclk),
    .rrst_n           (rrst_n),
    .fifo_rempty      (fifo_rempty),
    .fifo_rdata       (fifo_rdata),
    .fifo_read_enable (fifo_read_enable),
    .flush            (flush),
    .m                (mif),
    .word_count       (word_count)
  );

  always #5 rclk = ~rclk;

  logic [7:0]  fq[$];
  logic        force_empty = 1'b0;
  logic [31:0] obs_d[$];
  logic [3:0]  obs_k[$];
  logic [31:0] exp_w[$];
  logic [3:0]  exp_k[$];
  logic [7:0]  mb[$];
  int tot_words = 0;
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_rd = 0;
  int run = 0;
  int max_run = 0;
  int bad_rd = 0;
  int stable_err = 0;
  int vseen = 0;
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [31:0] pd = '0;
  logic [3:0]  pkp = '0;

  // FIFO with registered empty flag and 1-cycle read data
  always @(posedge rclk) begin
    if (fifo_read_enable && !fifo_rempty) begin
      fifo_rdata <= fq.pop_front();
    end
    fifo_rempty <= force_empty || (fq.size() == 0);
  end

  // Observe reads, handshakes and hold stability
  always @(posedge rclk) begin
    if (fifo_read_enable && fifo_rempty) bad_rd++;
    if (fifo_read_enable && !fifo_rempty) begin
      n_rd++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (mif.m_valid) vseen++;
    if (mif.m_valid && mif.m_ready) begin
      obs_d.push_back(mif.m_data);
      obs_k.push_back(mif.m_keep);
    end
    if (pv && !pr && (mif.m_valid !== 1'b1
        || mif.m_data !== pd || mif.m_keep !== pkp))
      stable_err++;
    pv  = mif.m_valid && rrst_n;
    pr  = mif.m_ready;
    pd  = mif.m_data;
    pkp = mif.m_keep;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge rclk);
  endtask

  // Model: bytes group in fours; a flush closes a group
  task automatic model_close();
    logic [31:0] w;
    if (mb.size() > 0) begin
      w = '0;
      for (int i = 0; i < mb.size(); i++)
        w[8*i +: 8] = mb[i];
      exp_w.push_back(w);
      exp_k.push_back(4'((1 << mb.size()) - 1));
      tot_words++;
      mb.delete();
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    mb.push_back(b);
    if (mb.size() == PK) model_close();
  endtask

  task automatic check_words(input string tag,
                             input int budget);
    logic [31:0] od;
    logic [3:0]  ok;
    int ne;
    ne = exp_w.size();
    for (int k = 0; k < budget
         && obs_d.size() < ne; k++)
      cyc(1);
    cyc(4);
    chk({tag, "_nwords"}, 64'(obs_d.size()), 64'(ne));
    for (int i = 0; i < ne; i++) begin
      od = (i < obs_d.size()) ? obs_d[i] : 'x;
      ok = (i < obs_k.size()) ? obs_k[i] : 'x;
      chk($sformatf("%s_data%0d", tag, i),
          64'(od), 64'(exp_w[i]));
      chk($sformatf("%s_keep%0d", tag, i),
          64'(ok), 64'(exp_k[i]));
    end
    obs_d.delete();
    obs_k.delete();
    exp_w.delete();
    exp_k.delete();
  endtask

  initial begin
    int pushed;
    mif.m_ready = 1'b0;

    // reset: outputs quiet even with data in FIFO
    cyc(2);
    fq.push_back(8'h55);
    cyc(3);
    chk("rst_rd_en", 64'(fifo_read_enable), 64'(0));
    chk("rst_valid", 64'(mif.m_valid), 64'(0));
    chk("rst_data", 64'(mif.m_data), 64'(0));
    chk("rst_keep", 64'(mif.m_keep), 64'(0));
    chk("rst_wc", 64'(word_count), 64'(0));
    fq.delete();
    cyc(2);
    rrst_n = 1'b1;
    cyc(2);

    // streaming
    mif.m_ready = 1'b1;
    max_run = 0;
    for (int b = 1; b <= 8; b++) push(8'(b));
    check_words("stream", 40);
    chk("stream_run", 64'(max_run), 64'(8));
    chk("stream_wc", 64'(word_count),
        64'(16'(tot_words)));

    // backpressure
    mif.m_ready = 1'b0;
    n_rd = 0;
    stable_err = 0;
    for (int b = 0; b < 12; b++)
      push(8'($urandom_range(0, 255)));
    cyc(16);
    chk("bp_reads", 64'(n_rd), 64'(8));
    chk("bp_left", 64'(fq.size()), 64'(4));
    chk("bp_valid", 64'(mif.m_valid), 64'(1));
    chk("bp_hold", 64'(mif.m_data), 64'(exp_w[0]));
    mif.m_ready = 1'b1;
    check_words("bp", 60);
    chk("bp_stable", 64'(stable_err), 64'(0));
    chk("bp_wc", 64'(word_count),
        64'(16'(tot_words)));

    // partial flush
    vseen = 0;
    push(8'hAA);
    push(8'hBB);
    push(8'hCC);
    cyc(10);
    chk("pf_noword", 64'(vseen), 64'(0));
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    model_close();
    check_words("pflush", 30);
    chk("pf_fifo_empty", 64'(fq.size()), 64'(0));
    chk("pf_rempty", 64'(fifo_rempty), 64'(1));

    // flush with nothing assembled
    vseen = 0;
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    cyc(10);
    chk("eflush_valid", 64'(vseen), 64'(0));
    chk("eflush_nobs", 64'(obs_d.size()), 64'(0));

    // flush on the edge the fourth byte lands
    n_rd = 0;
    for (int b = 0; b < 4; b++)
      push(8'($urandom_range(0, 255)));
    for (int k = 0; k < 50 && n_rd < 4; k++) cyc(1);
    chk("coll_reads", 64'(n_rd), 64'(4));
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    model_close();
    check_words("coll", 30);
    chk("coll_wc", 64'(word_count),
        64'(16'(tot_words)));

    // empty guard
    force_empty = 1'b1;
    push(8'h5A);
    push(8'hA5);
    n_rd = 0;
    vseen = 0;
    bad_rd = 0;
    cyc(20);
    chk("eg_reads", 64'(n_rd), 64'(0));
    chk("eg_valid", 64'(vseen), 64'(0));
    chk("eg_bad_rd", 64'(bad_rd), 64'(0));

    // reset with two lanes landed
    force_empty = 1'b0;
    for (int k = 0; k < 30 && n_rd < 2; k++) cyc(1);
    cyc(3);
    rrst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(mif.m_valid), 64'(0));
    chk("mrst_data", 64'(mif.m_data), 64'(0));
    chk("mrst_keep", 64'(mif.m_keep), 64'(0));
    chk("mrst_wc", 64'(word_count), 64'(0));
    chk("mrst_rd_en", 64'(fifo_read_enable), 64'(0));
    mb.delete();
    tot_words = 0;
    cyc(2);
    rrst_n = 1'b1;
    cyc(1);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    check_words("mrst_clean", 30);
    chk("mrst_clean_wc", 64'(word_count), 64'(1));

    // randomized traffic with random backpressure
    stable_err = 0;
    bad_rd = 0;
    pushed = 0;
    for (int c = 0; c < 300; c++) begin
      mif.m_ready = ($urandom_range(0, 3) != 0);
      if (pushed < 40 && $urandom_range(0, 1) == 1) begin
        push(8'($urandom_range(0, 255)));
        pushed++;
      end
      cyc(1);
    end
    mif.m_ready = 1'b1;
    check_words("rand", 400);
    chk("rand_stable", 64'(stable_err), 64'(0));
    chk("rand_bad_rd", 64'(bad_rd), 64'(0));
    chk("rand_wc", 64'(word_count),
        64'(16'(tot_words)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
